div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle sequencer for MIPS DIV/DIVU in the EX stage, running beside the single-cycle ALU.
- Captures operands on a start request and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline stall while busy and returns the result {remainder, quotient} for HI/LO writeback.
- Honours pipeline flush (annul) in every state.

Parameters:
- WIDTH, 32: operand width. Result width is 2*WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  EX holds a DIV/DIVU. Level signal, held by EX while stalled.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU. Sampled with start.
- a  in  WIDTH  dividend (rs). Sampled with start.
- b  in  WIDTH  divisor (rt). Sampled with start.
- annul  in  1  flush of the EX instruction. Aborts the operation.
- stall_o  out  1  pipeline stall request.
- ready_o  out  1  one-cycle result-valid pulse.
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, internal regs=0, stall_o=0, ready_o=0, result_o=0. Takes effect immediately, including mid-operation.
- States and transitions:
  - IDLE: if start=1 and annul=0, capture |a|, |b| (absolute values only when signed_div=1), the sign of a, sign(a)^sign(b), and signed_div. Go to DIVZERO if b==0, else go to ON with counter=0.
  - ON: each cycle, shift {rem,quo} left by 1. If rem >= divisor, subtract and set the quotient LSB. Increment counter. After iteration WIDTH-1 (counter==WIDTH-1), go to END.
  - DIVZERO: one cycle, then END. Result is quotient=all-ones, remainder=a (raw, unsigned view). No sign fix-up.
  - END: apply the sign fix-up and register result_o. ready_o=1 for exactly this cycle. Unconditionally go to IDLE next cycle.
- Sign fix-up (signed only):
  - Quotient negated if the quotient-sign flag is set.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF wraps naturally: quotient 0x80000000, remainder 0. No trap.
- stall_o (combinational):
  - 1 when (IDLE and start and not annul), or in ON, or in DIVZERO.
  - 0 in END and whenever annul=1.
- Latency, with start first seen in IDLE at cycle 0:
  - Normal divide: stall_o high cycles 0..WIDTH. ready_o and valid result_o in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Divide by zero: ready_o in cycle 2.
- start during END is ignored. The pipeline advances at the end of the END cycle, and a following divide is accepted from IDLE the next cycle.
- annul=1 in any state: next state IDLE, no ready_o pulse, result_o unchanged. start coincident with annul in IDLE is not accepted.
- result_o holds its last value until the next END. It is not cleared on accept or annul.
- Operands are frozen at accept. Changes on a/b/signed_div during ON have no effect.

Test Plan:
1. DIVU a=100, b=7, start held -> stall_o=1 cycles 0-32; ready_o=1 only in cycle 33; result_o={32'd2, 32'd14}; state IDLE in cycle 34.
2. DIV a=-7 (0xFFFFFFF9), b=2 -> ready cycle 33; quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with a=7, b=-2 -> quotient 0xFFFFFFFD, remainder 1.
3. DIVU a=0x12345678, b=0 -> stall_o=1 cycles 0-1; ready_o in cycle 2; result_o={0x12345678, 0xFFFFFFFF}.
4. DIV a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0, ready cycle 33. Also DIVU a=0xFFFFFFFF, b=1 -> quotient 0xFFFFFFFF, remainder 0.
5. Start 100/7, annul pulse in cycle 10:
   - stall_o=0 in cycle 10; IDLE in cycle 11; no ready_o.
   - New start DIVU 7/7 in cycle 11 -> ready cycle 44, result {0, 1}.
   - result_o between cycles 10 and 43 holds its prior value.
6. Start DIVU 9/3, resetn low in cycle 5:
   - All outputs 0 asynchronously in cycle 5.
   - After release, start 9/3 -> result {0, 3} after 33 cycles.
   - Back-to-back divides (start re-asserted the cycle after END) both complete with correct results.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in EX.
//            Stalls the pipeline while busy and returns {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
        S_DIVZERO = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_sign_a;
    logic                 r_sign_q;
    logic                 r_signed;
    logic                 r_ready;
    logic [2*WIDTH-1:0]   r_result;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_a_raw;
    logic                 w_last;

    assign w_abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

    // Shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_quo_fix = (r_signed && r_sign_q) ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = (r_signed && r_sign_a) ? -w_rem_nx : w_rem_nx;
    // r_quo still holds |a| in DIVZERO; negating again restores the raw dividend.
    assign w_a_raw   = (r_signed && r_sign_a) ? -r_quo : r_quo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_signed <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_ready <= 1'b0;
            if (annul) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_quo    <= w_abs_a;
                            r_dvs    <= w_abs_b;
                            r_rem    <= '0;
                            r_sign_a <= a[WIDTH-1];
                            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_signed <= signed_div;
                            r_cnt    <= '0;
                            r_state  <= (b == '0) ? S_DIVZERO : S_ON;
                        end
                    end
                    S_ON: begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state  <= S_END;
                            r_ready  <= 1'b1;
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                    S_DIVZERO: begin
                        r_state  <= S_END;
                        r_ready  <= 1'b1;
                        r_result <= {w_a_raw, {WIDTH{1'b1}}};
                    end
                    S_END: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign stall_o  = resetn && !annul &&
                      (((r_state == S_IDLE) && start) ||
                       (r_state == S_ON) || (r_state == S_DIVZERO));
    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Self-checking bench for div_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int          checks;
    int          errors;
    logic [63:0] last_exp;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_o    (stall_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] model(input logic sd, input logic [31:0] av, input logic [31:0] bv);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (!sd) return {av % bv, av / bv};
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle becomes cycle 0 of the op.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] exp;
        int lat;
        int stall_cnt;
        int early_ready;
        int changed;
        exp = model(sd, av, bv);
        lat = (bv == 32'd0) ? 2 : 33;
        stall_cnt = 0;
        early_ready = 0;
        changed = 0;
        start = 1'b1;
        signed_div = sd;
        a = av;
        b = bv;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (ready_o) early_ready++;
            if (result_o !== last_exp) changed++;
            @(posedge clk);
            #1;
            signed_div = 1'($urandom);
            a = $urandom;
            b = $urandom;
        end
        @(negedge clk);
        check({tag, ".ready"}, 64'(ready_o), 64'd1);
        check({tag, ".stall_end"}, 64'(stall_o), 64'd0);
        check({tag, ".result"}, result_o, exp);
        check({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(lat));
        check({tag, ".early_ready"}, 64'(early_ready), 64'd0);
        check({tag, ".held"}, 64'(changed), 64'd0);
        last_exp = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".ready"}, 64'(ready_o), 64'd0);
        check({tag, ".stall"}, 64'(stall_o), 64'd0);
        check({tag, ".result"}, result_o, last_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rsd;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        last_exp = 64'd0;
        resetn = 1'b0;
        start = 1'b0;
        signed_div = 1'b0;
        a = 32'd0;
        b = 32'd0;
        annul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stall", 64'(stall_o), 64'd0);
        check("reset.ready", 64'(ready_o), 64'd0);
        check("reset.result", result_o, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        check("divu_100_7.const", last_exp, {32'd2, 32'd14});
        idle_check("divu_100_7.idle");

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2.const", last_exp, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        check("div_7_m2.const", last_exp, {32'd1, 32'hFFFF_FFFD});
        run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0);
        check("divu_by0.const", last_exp, {32'h1234_5678, 32'hFFFF_FFFF});
        run_div("div_by0_neg", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.const", last_exp, {32'd0, 32'h8000_0000});
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        idle_check("divu_max_1.idle");

        // Annul in cycle 10 of 100/7, then 7/7 accepted in cycle 11.
        start = 1'b1;
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul.stall", 64'(stall_o), 64'd0);
        check("annul.ready", 64'(ready_o), 64'd0);
        check("annul.result", result_o, last_exp);
        @(posedge clk);
        #1;
        annul = 1'b0;
        run_div("after_annul_7_7", 1'b0, 32'd7, 32'd7);

        // Annul coincident with start in IDLE is not accepted.
        start = 1'b1;
        annul = 1'b1;
        a = 32'd50;
        b = 32'd5;
        @(negedge clk);
        check("annul_idle.stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        idle_check("annul_idle.idle");

        // Asynchronous reset in cycle 5 of 9/3.
        start = 1'b1;
        signed_div = 1'b0;
        a = 32'd9;
        b = 32'd3;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        #1;
        check("midreset.stall", 64'(stall_o), 64'd0);
        check("midreset.ready", 64'(ready_o), 64'd0);
        check("midreset.result", result_o, 64'd0);
        start = 1'b0;
        last_exp = 64'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_div("after_reset_9_3", 1'b0, 32'd9, 32'd3);
        run_div("b2b_1", 1'b1, 32'hFFFF_FF00, 32'd7);
        run_div("b2b_2", 1'b0, 32'd1000, 32'd33);

        for (int i = 0; i < 10; i++) begin
            rsd = 1'($urandom);
            ra = $urandom;
            case ($urandom % 4)
                0:       rb = 32'd0;
                1:       rb = $urandom % 256;
                default: rb = $urandom;
            endcase
            run_div($sformatf("rand%0d", i), rsd, ra, rb);
        end
        idle_check("final.idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
